multicycle_ctrl: RTL

// Multi-cycle control FSM for the 10-bit datapath; the driving end of the ALU's alu_ctrl/halt interface.

---
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 10-bit datapath: sequences fetch/decode/execute/
// memory/writeback and drives ALU control, register-file, PC, IR and memory strobes.
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       instr,
    input  logic             mem_ready,
    input  logic [9:0]       alu_result,
    input  logic             alu_halt,
    output logic [2:0]       alu_ctrl,
    output logic             alu_src_b,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);
    localparam int WC_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_LIMIT - 1);

    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_J    = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic [3:0]      opcode;
    logic            is_rtype;
    logic            is_lw;
    logic            requesting;
    logic            timeout;
    logic            unused_instr_bits;

    assign opcode            = instr[9:6];
    assign unused_instr_bits = ^instr[5:0];
    assign is_rtype          = (opcode <= 4'd5);
    assign is_lw             = (opcode == OP_LW);
    assign requesting        = (state == S_FETCH) || (state == S_MEM);
    // Fires on the last permitted low cycle so the access never exceeds WAIT_LIMIT waits.
    assign timeout           = requesting && !mem_ready && (wait_cnt == WC_LAST);

    always_comb begin
        alu_ctrl   = 3'b000;
        alu_src_b  = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state)
            S_FETCH: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_rtype) begin
                    alu_ctrl = opcode[2:0];
                end else begin
                    case (opcode)
                        OP_ADDI, OP_LW, OP_SW: alu_src_b = 1'b1;
                        OP_BEQ: begin
                            alu_ctrl = 3'b111;
                            if (alu_result == 10'h3FF) begin
                                pc_we  = 1'b1;
                                pc_src = 2'b01;
                            end
                        end
                        OP_J: begin
                            pc_we  = 1'b1;
                            pc_src = 2'b10;
                        end
                        OP_HALT: alu_ctrl = 3'b110;
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                iord      = 1'b1;
                alu_src_b = 1'b1;
                mem_re    = is_lw;
                mem_we    = !is_lw;
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            retired  <= '0;
            halted   <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            // Counter only runs while a request is outstanding, so every entry to FETCH/MEM sees 0.
            if (requesting && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
            else                          wait_cnt <= '0;

            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (timeout) begin
                        bus_err <= 1'b1;
                        halted  <= 1'b1;
                        state   <= S_HALTED;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (is_rtype || opcode == OP_ADDI) begin
                        state <= S_WB;
                    end else if (opcode == OP_LW || opcode == OP_SW) begin
                        state <= S_MEM;
                    end else if (opcode == OP_HALT) begin
                        if (alu_halt) begin
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else begin
                        retired <= retired + CNT_W'(1);
                        state   <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_lw) begin
                            state <= S_WB;
                        end else begin
                            retired <= retired + CNT_W'(1);
                            state   <= S_FETCH;
                        end
                    end else if (timeout) begin
                        bus_err <= 1'b1;
                        halted  <= 1'b1;
                        state   <= S_HALTED;
                    end
                end
                S_WB: begin
                    retired <= retired + CNT_W'(1);
                    state   <= S_FETCH;
                end
                default:  state <= S_HALTED;
            endcase
        end
    end
endmodule
